branch_predict_unit: RTL and testbench

//  Parametrised branch prediction and resolution unit; successor to the combinational branch compare.

---
 rtl/branch_predict_unit_pkg.sv | 23 ++
 rtl/branch_predict_unit_cond.sv | 33 +++
 rtl/branch_predict_unit.sv | 152 +++++++++++++++
 tb/tb_branch_predict_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared types for the branch prediction unit: machine word, branch condition codes, redirect bundle.
package branch_predict_unit_pkg;

    typedef logic [63:0] word_t;
    typedef logic        u1;

    typedef enum logic [3:0] {
        BRH_NEV  = 4'd0,
        BRH_AWS  = 4'd1,
        BRH_EQL  = 4'd2,
        BRH_NEQ  = 4'd3,
        BRH_LST  = 4'd4,
        BRH_GOE  = 4'd5,
        BRH_LSTU = 4'd6,
        BRH_GOEU = 4'd7
    } branchfunc_t;

    typedef struct packed {
        u1     valid;
        word_t pc;
    } bpu_redirect_t;

endpackage

// File: rtl/branch_predict_unit_cond.sv
// Branch condition evaluator: decides taken/not-taken from the condition code and operands.
// Latency: purely combinational.
// Backpressure: none; output follows inputs every cycle.
module branch_predict_unit_cond
    import branch_predict_unit_pkg::*;
(
    input  branchfunc_t branchfunc,
    input  word_t       src1,
    input  word_t       src2,
    input  word_t       pc,
    input  word_t       target,
    output u1           taken
);

    always_comb begin
        taken = 1'b0;
        case (branchfunc)
            BRH_AWS:  taken = 1'b1;
            BRH_EQL:  taken = (src1 == src2);
            BRH_NEQ:  taken = (src1 != src2);
            BRH_LST:  taken = ($signed(src1) <  $signed(src2));
            BRH_GOE:  taken = ($signed(src1) >= $signed(src2));
            BRH_LSTU: taken = (src1 <  src2);
            BRH_GOEU: taken = (src1 >= src2);
            default:  taken = 1'b0;
        endcase
        // A branch to itself would spin forever; treat it as falling through.
        if (target == pc) begin
            taken = 1'b0;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB + saturating direction counters; resolves branches in execute and redirects fetch.
// Latency: lookup 0 cycles from table flops; redirect 1 cycle after execute; training visible next cycle.
// Backpressure: none; one lookup and one resolution accepted every cycle.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_valid,
    input  word_t             f_pc,
    output logic              f_pred_taken,
    output word_t             f_pred_target,
    input  logic              ex_valid,
    input  logic              ex_kill,
    input  branchfunc_t       ex_branchfunc,
    input  word_t             ex_pc,
    input  word_t             ex_src1,
    input  word_t             ex_src2,
    input  word_t             ex_target,
    input  logic              ex_pred_taken,
    input  word_t             ex_pred_target,
    output logic              redirect_valid,
    output word_t             redirect_pc,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredict
);

    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(2 ** (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(2 ** (CNT_W - 1) - 1);

    typedef struct packed {
        u1                valid;
        logic [TAG_W-1:0] tag;
        word_t            target;
        logic [CNT_W-1:0] cnt;
    } bpu_entry_t;

    bpu_entry_t    tbl [ENTRIES];
    bpu_redirect_t redirect_q;

    // Fetch-side lookup.
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    bpu_entry_t       f_ent;
    logic             f_hit;

    assign f_idx         = f_pc[IDX_W+1:2];
    assign f_tag         = f_pc[IDX_W+2 +: TAG_W];
    assign f_ent         = tbl[f_idx];
    assign f_hit         = f_ent.valid && (f_ent.tag == f_tag);
    assign f_pred_taken  = f_valid && f_hit && f_ent.cnt[CNT_W-1];
    assign f_pred_target = f_pred_taken ? f_ent.target : f_pc + 64'd4;

    // Execute-side resolution.
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    bpu_entry_t       ex_ent;
    bpu_entry_t       ex_new;
    logic             ex_hit;
    logic             ex_taken;
    logic             ex_act;
    logic             ex_mispredict;

    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[IDX_W+2 +: TAG_W];
    assign ex_ent = tbl[ex_idx];
    assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);

    branch_predict_unit_cond u_cond (
        .branchfunc (ex_branchfunc),
        .src1       (ex_src1),
        .src2       (ex_src2),
        .pc         (ex_pc),
        .target     (ex_target),
        .taken      (ex_taken)
    );

    assign ex_act        = ex_valid && !ex_kill && (ex_branchfunc != BRH_NEV);
    assign ex_mispredict = ex_act && ((ex_taken != ex_pred_taken) ||
                                      (ex_taken && (ex_target != ex_pred_target)));

    always_comb begin
        ex_new = ex_ent;
        if (ex_taken) begin
            if (ex_hit) begin
                ex_new.target = ex_target;
                ex_new.cnt    = (ex_ent.cnt == CNT_MAX) ? CNT_MAX : ex_ent.cnt + CNT_W'(1);
            end else begin
                ex_new.valid  = 1'b1;
                ex_new.tag    = ex_tag;
                ex_new.target = ex_target;
                ex_new.cnt    = CNT_WEAK_T;
            end
            // Unconditional jumps go straight to strongly taken.
            if (ex_branchfunc == BRH_AWS) begin
                ex_new.cnt = CNT_MAX;
            end
        end else if (ex_hit && (ex_ent.cnt != '0)) begin
            ex_new.cnt = ex_ent.cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i].valid  <= 1'b0;
                tbl[i].tag    <= '0;
                tbl[i].target <= '0;
                tbl[i].cnt    <= CNT_WEAK_NT;
            end
        end else if (ex_act) begin
            tbl[ex_idx] <= ex_new;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_q <= '0;
        end else begin
            redirect_q.valid <= ex_mispredict;
            if (ex_mispredict) begin
                redirect_q.pc <= ex_taken ? ex_target : ex_pc + 64'd4;
            end
        end
    end

    assign redirect_valid = redirect_q.valid;
    assign redirect_pc    = redirect_q.pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_branches   <= '0;
            perf_mispredict <= '0;
        end else begin
            if (ex_act && (perf_branches != '1)) begin
                perf_branches <= perf_branches + PERF_W'(1);
            end
            if (ex_mispredict && (perf_mispredict != '1)) begin
                perf_mispredict <= perf_mispredict + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed scenarios plus randomized traffic against a table-level model.
module tb_branch_predict_unit;
    import branch_predict_unit_pkg::*;

    localparam int ENTRIES = 64;
    localparam int PERF_W  = 32;

    localparam word_t P00 = 64'h8000_0000;
    localparam word_t P10 = 64'h8000_0010;
    localparam word_t P14 = 64'h8000_0014;
    localparam word_t P40 = 64'h8000_0040;

    logic              clk = 1'b0;
    logic              reset;
    logic              f_valid;
    word_t             f_pc;
    logic              f_pred_taken;
    word_t             f_pred_target;
    logic              ex_valid;
    logic              ex_kill;
    branchfunc_t       ex_branchfunc;
    word_t             ex_pc, ex_src1, ex_src2, ex_target, ex_pred_target;
    logic              ex_pred_taken;
    logic              redirect_valid;
    word_t             redirect_pc;
    logic [PERF_W-1:0] perf_branches, perf_mispredict;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(.ENTRIES(64), .TAG_W(8), .CNT_W(2), .PERF_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .f_valid         (f_valid),
        .f_pc            (f_pc),
        .f_pred_taken    (f_pred_taken),
        .f_pred_target   (f_pred_target),
        .ex_valid        (ex_valid),
        .ex_kill         (ex_kill),
        .ex_branchfunc   (ex_branchfunc),
        .ex_pc           (ex_pc),
        .ex_src1         (ex_src1),
        .ex_src2         (ex_src2),
        .ex_target       (ex_target),
        .ex_pred_taken   (ex_pred_taken),
        .ex_pred_target  (ex_pred_target),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .perf_branches   (perf_branches),
        .perf_mispredict (perf_mispredict)
    );

    // Reference model: plain arrays indexed by (pc/4) mod ENTRIES, tag = (pc/256) mod 256.
    bit          m_valid [ENTRIES];
    int          m_tag   [ENTRIES];
    word_t       m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    longint      m_br, m_mis;
    bit          m_rv;
    word_t       m_rpc;

    function automatic int m_idx(input word_t pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int m_tagof(input word_t pc);
        return int'((pc / 256) % 256);
    endfunction

    function automatic bit m_cond(input branchfunc_t bf, input word_t a, input word_t b,
                                  input word_t pc, input word_t tgt);
        if (tgt == pc) return 1'b0;
        case (bf)
            BRH_AWS:  return 1'b1;
            BRH_EQL:  return a == b;
            BRH_NEQ:  return a != b;
            BRH_LST:  return longint'(a) <  longint'(b);
            BRH_GOE:  return longint'(a) >= longint'(b);
            BRH_LSTU: return a <  b;
            BRH_GOEU: return a >= b;
            default:  return 1'b0;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_cnt[i] = 1;
        end
        m_br = 0; m_mis = 0; m_rv = 0; m_rpc = '0;
    endtask

    task automatic m_lookup(input bit v, input word_t pc, output bit t, output word_t tgt);
        int i;
        i   = m_idx(pc);
        t   = v && m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_cnt[i] >= 2);
        tgt = t ? m_tgt[i] : pc + 4;
    endtask

    task automatic m_exec();
        bit t, act, mis, hit;
        int i;
        t   = m_cond(ex_branchfunc, ex_src1, ex_src2, ex_pc, ex_target);
        act = ex_valid && !ex_kill && (ex_branchfunc != BRH_NEV);
        mis = act && ((t != ex_pred_taken) || (t && ex_target != ex_pred_target));
        m_rv = mis;
        if (mis) m_rpc = t ? ex_target : ex_pc + 4;
        if (act) begin
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (mis && m_mis < 64'hFFFF_FFFF) m_mis++;
            i   = m_idx(ex_pc);
            hit = m_valid[i] && (m_tag[i] == m_tagof(ex_pc));
            if (t) begin
                if (hit) begin
                    m_tgt[i] = ex_target;
                    m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
                end else begin
                    m_valid[i] = 1; m_tag[i] = m_tagof(ex_pc); m_tgt[i] = ex_target; m_cnt[i] = 2;
                end
                if (ex_branchfunc == BRH_AWS) m_cnt[i] = 3;
            end else if (hit) begin
                m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
            end
        end
    endtask

    task automatic set_ex(input bit v, input bit k, input branchfunc_t bf, input word_t pc,
                          input word_t s1, input word_t s2, input word_t tgt,
                          input bit pt, input word_t ptgt);
        ex_valid = v; ex_kill = k; ex_branchfunc = bf; ex_pc = pc;
        ex_src1 = s1; ex_src2 = s2; ex_target = tgt;
        ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    task automatic idle_ex();
        set_ex(0, 0, BRH_NEV, '0, '0, '0, '0, 0, '0);
    endtask

    task automatic cycle();
        m_exec();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; f_valid = 1'b0; f_pc = '0; idle_ex();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %0b want 0", redirect_valid); end
        checks++; if (perf_branches !== '0 || perf_mispredict !== '0) begin
            errors++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_branches, perf_mispredict); end
        m_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        f_valid = 1'b1; f_pc = P00; #1;
        checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_lookup_taken got %0b want 0", f_pred_taken); end
        checks++; if (f_pred_target !== 64'h8000_0004) begin errors++; $display("FAIL reset_lookup_target got %h want 80000004", f_pred_target); end
    endtask

    task automatic test_first_taken();
        set_ex(1, 0, BRH_EQL, P10, 5, 5, P40, 0, P14);
        cycle();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL first_rv got %0b want 1", redirect_valid); end
        checks++; if (redirect_pc !== P40) begin errors++; $display("FAIL first_rpc got %h want %h", redirect_pc, P40); end
        idle_ex(); f_valid = 1; f_pc = P10; #1;
        checks++; if (f_pred_taken !== 1'b1 || f_pred_target !== P40) begin
            errors++; $display("FAIL first_lookup got %0b/%h want 1/%h", f_pred_taken, f_pred_target, P40); end
    endtask

    task automatic test_saturate_train();
        for (int n = 0; n < 3; n++) begin
            set_ex(1, 0, BRH_EQL, P10, 5, 5, P40, 1, P40);
            cycle();
            checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL sat_taken_rv%0d got %0b want 0", n, redirect_valid); end
        end
        set_ex(1, 0, BRH_NEQ, P10, 5, 5, P40, 1, P40);
        cycle();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== P14) begin
            errors++; $display("FAIL sat_nt1_redirect got %0b/%h want 1/%h", redirect_valid, redirect_pc, P14); end
        f_pc = P10; #1;
        checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("FAIL sat_cnt2_lookup got %0b want 1", f_pred_taken); end
        cycle();
        idle_ex(); #1;
        checks++; if (f_pred_taken !== 1'b0 || f_pred_target !== P14) begin
            errors++; $display("FAIL sat_cnt1_lookup got %0b/%h want 0/%h", f_pred_taken, f_pred_target, P14); end
        checks++; if (perf_branches !== 32'd6 || perf_mispredict !== 32'd3) begin
            errors++; $display("FAIL sat_perf got %0d/%0d want 6/3", perf_branches, perf_mispredict); end
    endtask

    task automatic test_alias();
        word_t a;
        a = 64'h8000_0110;
        f_valid = 1; f_pc = a; #1;
        checks++; if (f_pred_taken !== 1'b0 || f_pred_target !== a + 4) begin
            errors++; $display("FAIL alias_lookup got %0b/%h want 0/%h", f_pred_taken, f_pred_target, a + 4); end
        set_ex(1, 0, BRH_EQL, a, 1, 2, a + 64'h30, 0, a + 4);
        cycle();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL alias_rv got %0b want 0", redirect_valid); end
        // A missed not-taken must leave the aliased counter at 1, so one taken lifts it to predicted-taken.
        set_ex(1, 0, BRH_EQL, P10, 5, 5, P40, 0, P14);
        cycle();
        idle_ex(); f_pc = P10; #1;
        checks++; if (f_pred_taken !== 1'b1 || f_pred_target !== P40) begin
            errors++; $display("FAIL alias_intact got %0b/%h want 1/%h", f_pred_taken, f_pred_target, P40); end
    endtask

    task automatic test_aws();
        word_t p2, p3, p4;
        p2 = 64'h8000_0200; p3 = 64'h8000_0300; p4 = 64'h8000_0400;
        set_ex(1, 0, BRH_AWS, p2, 0, 0, p2, 1, p2);
        cycle();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== p2 + 4) begin
            errors++; $display("FAIL aws_self_pred1 got %0b/%h want 1/%h", redirect_valid, redirect_pc, p2 + 4); end
        set_ex(1, 0, BRH_AWS, p2, 0, 0, p2, 0, p2 + 4);
        cycle();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL aws_self_pred0 got %0b want 0", redirect_valid); end
        idle_ex(); f_valid = 1; f_pc = p2; #1;
        checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL aws_self_noalloc got %0b want 0", f_pred_taken); end
        set_ex(1, 0, BRH_AWS, p3, 0, 0, p4, 0, p3 + 4);
        cycle();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== p4) begin
            errors++; $display("FAIL aws_jump got %0b/%h want 1/%h", redirect_valid, redirect_pc, p4); end
        set_ex(1, 0, BRH_NEQ, p3, 7, 7, p4, 1, p4);
        cycle();
        idle_ex(); f_pc = p3; #1;
        checks++; if (f_pred_taken !== 1'b1 || f_pred_target !== p4) begin
            errors++; $display("FAIL aws_strong got %0b/%h want 1/%h", f_pred_taken, f_pred_target, p4); end
    endtask

    function automatic word_t rand_pc();
        return 64'h8000_0000 | word_t'($urandom_range(0, 7) << 2) | word_t'($urandom_range(0, 1) << 8);
    endfunction

    function automatic word_t rand_op();
        case ($urandom_range(0, 4))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return 64'd5;
            default: return 64'h8000_0000_0000_0000;
        endcase
    endfunction

    task automatic test_random();
        bit    lt, pt;
        word_t lg, pc, tgt, ptgt;
        for (int n = 0; n < 400; n++) begin
            pc  = rand_pc();
            tgt = ($urandom_range(0, 7) == 0) ? pc : (rand_pc() | word_t'($urandom_range(0, 1) << 12));
            m_lookup(1'b1, pc, lt, lg);
            if ($urandom_range(0, 1) == 1) begin pt = lt; ptgt = lg; end
            else begin pt = 1'($urandom_range(0, 1)); ptgt = pt ? tgt : pc + 4; end
            set_ex(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 9) == 0),
                   branchfunc_t'(4'($urandom_range(0, 9))), pc, rand_op(), rand_op(), tgt, pt, ptgt);
            f_valid = 1'($urandom_range(0, 3) != 0);
            f_pc    = rand_pc();
            #1;
            m_lookup(f_valid, f_pc, lt, lg);
            checks++; if (f_pred_taken !== lt || f_pred_target !== lg) begin
                errors++; $display("FAIL rnd_lookup[%0d] got %0b/%h want %0b/%h", n, f_pred_taken, f_pred_target, lt, lg); end
            cycle();
            checks++; if (redirect_valid !== m_rv || redirect_pc !== m_rpc) begin
                errors++; $display("FAIL rnd_redirect[%0d] got %0b/%h want %0b/%h", n, redirect_valid, redirect_pc, m_rv, m_rpc); end
            checks++; if (perf_branches !== PERF_W'(m_br) || perf_mispredict !== PERF_W'(m_mis)) begin
                errors++; $display("FAIL rnd_perf[%0d] got %0d/%0d want %0d/%0d", n, perf_branches, perf_mispredict, m_br, m_mis); end
        end
        idle_ex();
    endtask

    task automatic test_kill_and_reset();
        word_t k;
        longint br0, mis0;
        k = 64'h8000_0500;
        br0 = m_br; mis0 = m_mis;
        set_ex(1, 1, BRH_EQL, k, 3, 3, k + 64'h100, 0, k + 4);
        cycle();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL kill_rv got %0b want 0", redirect_valid); end
        checks++; if (perf_branches !== PERF_W'(br0) || perf_mispredict !== PERF_W'(mis0)) begin
            errors++; $display("FAIL kill_perf got %0d/%0d want %0d/%0d", perf_branches, perf_mispredict, br0, mis0); end
        set_ex(1, 0, BRH_EQL, k, 3, 3, k + 64'h100, 1, k + 64'h100);
        f_valid = 1; f_pc = k; #1;
        checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL kill_notrain got %0b want 0", f_pred_taken); end
        set_ex(1, 0, BRH_EQL, k, 3, 3, k + 64'h100, 0, k + 4);
        cycle();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL prereset_rv got %0b want 1", redirect_valid); end
        idle_ex();
        #1 reset = 1'b0;
        #1;
        m_reset();
        checks++; if (redirect_valid !== 1'b0 || redirect_pc !== '0) begin
            errors++; $display("FAIL midreset_redirect got %0b/%h want 0/0", redirect_valid, redirect_pc); end
        checks++; if (perf_branches !== '0 || perf_mispredict !== '0) begin
            errors++; $display("FAIL midreset_perf got %0d/%0d want 0/0", perf_branches, perf_mispredict); end
        f_pc = P10; #1;
        checks++; if (f_pred_taken !== 1'b0 || f_pred_target !== P14) begin
            errors++; $display("FAIL midreset_lookup got %0b/%h want 0/%h", f_pred_taken, f_pred_target, P14); end
        f_pc = k; #1;
        checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("FAIL midreset_lookup_k got %0b want 0", f_pred_taken); end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_first_taken();
        test_saturate_train();
        test_alias();
        test_aws();
        test_random();
        test_kill_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
